// File: rtl/snn_div_pkg.sv
// Shared defaults, datapath widths and FSM encoding for the reciprocal divider.
package snn_div_pkg;
   localparam int NUMERATOR_DEF = 38250;
   localparam int SAT_MAX_DEF   = 1250;
   localparam int IN_W_DEF      = 8;
   localparam int OUT_W_DEF     = 11;
   localparam int DVD_W         = 16;
   localparam int CNT_W         = 4;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/serial_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle MSB first; 16 iterations after start.
// done flags the final iteration, and quotient is complete while done is high.
module serial_divider
   import snn_div_pkg::*;
#(
   parameter int DIV_W = IN_W_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [DVD_W-1:0] dividend,
   input  logic [DIV_W-1:0] divisor,
   output logic             done,
   output logic [DVD_W-1:0] quotient
);
   logic [DVD_W:0]   rem;
   logic [DVD_W-1:0] quo;
   logic [DIV_W-1:0] dsr;
   logic [CNT_W-1:0] cnt;
   logic             busy;
   logic [DVD_W+1:0] shifted;
   logic [DVD_W+1:0] trial;
   logic             fits;

   // quo doubles as the dividend shift register; quotient bits enter at the LSB
   always_comb begin
      shifted = {rem, quo[DVD_W-1]};
      trial   = shifted - (DVD_W+2)'(dsr);
      fits    = ~trial[DVD_W+1];
   end

   assign done     = busy && (cnt == CNT_W'(DVD_W-1));
   assign quotient = {quo[DVD_W-2:0], fits};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem  <= '0;
         quo  <= '0;
         dsr  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         rem  <= '0;
         quo  <= dividend;
         dsr  <= divisor;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         rem  <= fits ? trial[DVD_W:0] : shifted[DVD_W:0];
         quo  <= quotient;
         cnt  <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/inverse_divide.sv
// Reconstructs a magnitude from a reciprocal code: min(SAT_MAX, round(NUMERATOR / val_in)).
// One code in flight: 17-cycle latency (1 for code 0), result held until out_ready.
module inverse_divide
   import snn_div_pkg::*;
#(
   parameter int NUMERATOR = NUMERATOR_DEF,
   parameter int SAT_MAX   = SAT_MAX_DEF,
   parameter int IN_W      = IN_W_DEF,
   parameter int OUT_W     = OUT_W_DEF
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  val_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] val_out,
   output logic             sat
);
   state_t           state, state_nxt;
   logic [OUT_W-1:0] val_nxt;
   logic             sat_nxt;
   logic             div_start;
   logic             div_done;
   logic [DVD_W-1:0] dividend;
   logic [DVD_W-1:0] quotient;

   // adding half the divisor turns the floor division into round-to-nearest
   assign dividend = DVD_W'(NUMERATOR) + DVD_W'(val_in >> 1);

   serial_divider #(.DIV_W(IN_W)) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (val_in),
      .done     (div_done),
      .quotient (quotient)
   );

   always_comb begin
      state_nxt = state;
      val_nxt   = val_out;
      sat_nxt   = sat;
      div_start = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (val_in == '0) begin
                  state_nxt = DONE;
                  val_nxt   = OUT_W'(SAT_MAX);
                  sat_nxt   = 1'b1;
               end else begin
                  state_nxt = CALC;
                  div_start = 1'b1;
               end
            end
         end
         CALC: begin
            if (div_done) begin
               state_nxt = DONE;
               if (quotient > DVD_W'(SAT_MAX)) begin
                  val_nxt = OUT_W'(SAT_MAX);
                  sat_nxt = 1'b1;
               end else begin
                  val_nxt = OUT_W'(quotient);
                  sat_nxt = 1'b0;
               end
            end
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         val_out <= '0;
         sat     <= 1'b0;
      end else begin
         state   <= state_nxt;
         val_out <= val_nxt;
         sat     <= sat_nxt;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
endmodule
